nibbler_gen: RTL and testbench
==============================

NIBBLER_GEN -- requirements
Module: nibbler_gen

Interface
REQ-001 Parameter DATA_W, 4: accumulator, operand and data-memory address width; SHALL be 4..16.
REQ-002 Parameter ADDR_W, 12: program counter width; SHALL satisfy ADDR_W <= 2*DATA_W+4.
REQ-003 Parameter STACK_DEPTH, 4: return-stack entries; SHALL be 1..16.
REQ-004 Instruction word width IW SHALL be 4+DATA_W: opcode [IW-1:DATA_W], operand [DATA_W-1:0].
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 imem_req  out  1  program fetch request; imem_addr  out  ADDR_W  fetch address (= pc).
REQ-008 imem_ack  in  1  fetch complete this cycle; imem_rdata  in  IW  fetched word, valid with imem_ack.
REQ-009 dmem_addr  out  DATA_W  = operand; dmem_we  out  1  write strobe; dmem_wdata  out  DATA_W  = acc; dmem_rdata  in  DATA_W  asynchronous-read data.
REQ-010 in_port  in  DATA_W  input port; out_port  out  DATA_W  output register; out_strobe  out  1  one-cycle pulse on OUT.
REQ-011 acc  out  DATA_W; pc  out  ADDR_W; carry, zero  out  1 each (active-high); exec_phase  out  1  high in EXEC/ADDR states; halted  out  1; stack_err  out  1  sticky.

Function
REQ-012 States SHALL be FETCH, EXEC, ADDR, HALT.
REQ-013 FETCH: imem_req=1; on imem_ack, ir <= imem_rdata, pc <= pc+1 (wraps mod 2^ADDR_W); next ADDR if opcode is JMP/JC/JNZ/CALL, else EXEC; without ack, stay, all state held.
REQ-014 Opcodes: 0 LIT acc<=op; 1 ADDI; 2 SUBI; 3 CMPI; 4 NANDI; 5 LD acc<=dmem_rdata; 6 ST; 7 IN acc<=in_port; 8 OUT; 9 JMP; A JC; B JNZ; C CALL; D RET; E ADDM acc<=acc+dmem_rdata; F HALT.
REQ-015 EXEC SHALL complete in one cycle, then FETCH; zero-wait non-jump instruction = 2 cycles.
REQ-016 ADDI/ADDM: {carry,acc} <= acc+x; zero <= (result==0).
REQ-017 SUBI: acc <= acc-op; carry <= 1 when no borrow (acc>=op); CMPI updates carry/zero identically, acc unchanged.
REQ-018 NANDI: acc <= ~(acc&op); zero updated; carry unchanged; all other opcodes leave flags unchanged.
REQ-019 ST SHALL assert dmem_we for exactly the EXEC cycle; OUT loads out_port and pulses out_strobe that cycle.
REQ-020 ADDR: imem_req=1 at pc; on ack, target = low ADDR_W bits of {operand, imem_rdata}; taken -> pc<=target, else pc<=pc+1; next FETCH.
REQ-021 Taken: JMP always, JC if carry, JNZ if !zero, CALL always.
REQ-022 CALL SHALL push pc+1 (address after the target word) before jumping; RET pops into pc in EXEC.
REQ-023 CALL with stack full or RET with stack empty: stack_err<=1, pc unchanged, stack unchanged, next HALT.
REQ-024 HALT: imem_req=0, dmem_we=0, halted=1; exit only by reset.
REQ-025 Simultaneous full/empty boundary: push to depth STACK_DEPTH-1 succeeds; stack SHALL hold exactly STACK_DEPTH entries.

Reset
REQ-026 reset asserted SHALL immediately force: state FETCH, pc=0, acc=0, carry=0, zero=0, sp=0, out_port=0, halted=0, stack_err=0, out_strobe=0, dmem_we=0.
REQ-027 Reset mid-fetch SHALL abandon the request; imem_req reasserts at address 0 the first cycle after release.

Structure
REQ-028 Package nibbler_pkg SHALL hold the opcode enum (4 bits) and state enum.
REQ-029 Sub-module nibbler_alu (parametrised DATA_W, combinational: add/sub/nand, carry/zero out) SHALL be instantiated once.

Verification
REQ-030 Reset, zero-wait ROM: LIT 5, ADDI 3, OUT -> out_port=8, out_strobe one pulse, each instruction 2 cycles.
REQ-031 DATA_W=4: LIT F, ADDI 1 -> acc=0, carry=1, zero=1; then JNZ skipped, JC to 0x123 -> pc=0x123.
REQ-032 imem_ack held low 3 cycles in FETCH -> pc, acc, flags unchanged, imem_addr stable.
REQ-033 STACK_DEPTH=2: CALL, CALL, CALL -> third sets stack_err=1, halted=1, pc=third CALL's ADDR-word address+0 held; separate RET on empty -> same.
REQ-034 ST to address 3 with acc=A, LD 3 -> dmem_we one cycle, acc=A; reset asserted during EXEC -> all outputs to reset values immediately.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler processor: opcode and FSM state encodings
// plus the ALU operation select.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_LIT   = 4'h0,
    OP_ADDI  = 4'h1,
    OP_SUBI  = 4'h2,
    OP_CMPI  = 4'h3,
    OP_NANDI = 4'h4,
    OP_LD    = 4'h5,
    OP_ST    = 4'h6,
    OP_IN    = 4'h7,
    OP_OUT   = 4'h8,
    OP_JMP   = 4'h9,
    OP_JC    = 4'hA,
    OP_JNZ   = 4'hB,
    OP_CALL  = 4'hC,
    OP_RET   = 4'hD,
    OP_ADDM  = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_ADDR,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NAND
  } alu_op_t;

  // Opcodes followed by a second word holding the low target bits
  function automatic logic is_branch(input opcode_t op);
    return (op == OP_JMP) || (op == OP_JC) || (op == OP_JNZ) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/nibbler_alu.sv
// Combinational ALU: add, subtract (carry = no borrow) and nand, with
// carry and zero flags derived from the result.
module nibbler_alu
  import nibbler_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero_out
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide      = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        carry_out = wide[DATA_W];
      end
      ALU_SUB: begin
        // The extra top bit becomes 1 exactly when a < b
        wide      = {1'b0, a} - {1'b0, b};
        carry_out = ~wide[DATA_W];
      end
      ALU_NAND: begin
        wide = {1'b0, ~(a & b)};
      end
      default: begin
        wide = '0;
      end
    endcase
    result   = wide[DATA_W-1:0];
    zero_out = (wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/nibbler_gen.sv
// Accumulator processor with a fetch/exec/addr/halt FSM, a small return
// stack and two-word branches whose second word supplies the low target bits.
module nibbler_gen
  import nibbler_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W+3:0] imem_rdata,
  output logic [DATA_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              zero,
  output logic              exec_phase,
  output logic              halted,
  output logic              stack_err
);

  localparam int IW   = 4 + DATA_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  state_t              state;
  logic [IW-1:0]       ir;
  opcode_t             opcode;
  logic [DATA_W-1:0]   operand;
  logic [SP_W-1:0]     sp;
  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0]   ret_addr;
  logic [ADDR_W-1:0]   pc_next;
  logic [2*DATA_W+3:0] target_full;
  logic [ADDR_W-1:0]   target;
  logic                stack_full;
  logic                stack_empty;
  logic                taken;
  logic                push;
  alu_op_t             alu_op;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic                alu_zero;

  assign opcode      = opcode_t'(ir[IW-1:DATA_W]);
  assign operand     = ir[DATA_W-1:0];
  assign pc_next     = pc + ADDR_W'(1);
  assign target_full = {operand, imem_rdata};
  assign target      = target_full[ADDR_W-1:0];
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign taken       = (opcode == OP_JMP) || (opcode == OP_CALL) ||
                       ((opcode == OP_JC) && carry) || ((opcode == OP_JNZ) && !zero);
  assign push        = (state == ST_ADDR) && imem_ack && (opcode == OP_CALL) && !stack_full;

  assign alu_op = ((opcode == OP_SUBI) || (opcode == OP_CMPI)) ? ALU_SUB :
                  (opcode == OP_NANDI) ? ALU_NAND : ALU_ADD;
  assign alu_b  = (opcode == OP_ADDM) ? dmem_rdata : operand;

  nibbler_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (alu_op),
    .a        (acc),
    .b        (alu_b),
    .result   (alu_result),
    .carry_out(alu_carry),
    .zero_out (alu_zero)
  );

  assign imem_req   = (state == ST_FETCH) || (state == ST_ADDR);
  assign imem_addr  = pc;
  assign dmem_addr  = operand;
  assign dmem_wdata = acc;
  assign dmem_we    = (state == ST_EXEC) && (opcode == OP_ST);
  assign out_strobe = (state == ST_EXEC) && (opcode == OP_OUT);
  assign exec_phase = (state == ST_EXEC) || (state == ST_ADDR);
  assign halted     = (state == ST_HALT);

  // Entry sp-1 is the top of stack
  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) ret_addr = stack_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (sp == SP_W'(i)) stack_mem[i] <= pc_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      ir        <= '0;
      pc        <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      sp        <= '0;
      out_port  <= '0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            pc    <= pc_next;
            state <= is_branch(opcode_t'(imem_rdata[IW-1:DATA_W])) ? ST_ADDR : ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          case (opcode)
            OP_LIT: acc <= operand;
            OP_ADDI, OP_ADDM, OP_SUBI: begin
              acc   <= alu_result;
              carry <= alu_carry;
              zero  <= alu_zero;
            end
            OP_CMPI: begin
              carry <= alu_carry;
              zero  <= alu_zero;
            end
            OP_NANDI: begin
              acc  <= alu_result;
              zero <= alu_zero;
            end
            OP_LD:  acc      <= dmem_rdata;
            OP_IN:  acc      <= in_port;
            OP_OUT: out_port <= acc;
            OP_RET: begin
              if (stack_empty) begin
                stack_err <= 1'b1;
                state     <= ST_HALT;
              end else begin
                pc <= ret_addr;
                sp <= sp - SP_W'(1);
              end
            end
            OP_HALT: state <= ST_HALT;
            default: ;
          endcase
        end
        ST_ADDR: begin
          if (imem_ack) begin
            // A CALL that cannot push halts with pc still at the target word
            if ((opcode == OP_CALL) && stack_full) begin
              stack_err <= 1'b1;
              state     <= ST_HALT;
            end else begin
              if (opcode == OP_CALL) sp <= sp + SP_W'(1);
              pc    <= taken ? target : pc_next;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_nibbler_gen.sv
// Bench for nibbler_gen: instruction-level reference model compared every
// cycle, plus directed programs with hand-computed checkpoints.
module tb_nibbler_gen;

  localparam int DW = 4;
  localparam int AW = 12;
  localparam int SD = 2;
  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_ADDR  = 2;
  localparam int PH_HALT  = 3;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW+3:0] imem_rdata;
  logic [DW-1:0] dmem_addr;
  logic          dmem_we;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic          out_strobe;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
  logic          carry;
  logic          zero;
  logic          exec_phase;
  logic          halted;
  logic          stack_err;

  logic          stall;
  logic [7:0]    rom [4096];
  logic [DW-1:0] env_mem [16];
  int            n_checks;
  int            n_fail;

  nibbler_gen #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe),
    .acc(acc), .pc(pc), .carry(carry), .zero(zero),
    .exec_phase(exec_phase), .halted(halted), .stack_err(stack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_rdata = rom[imem_addr];
  assign imem_ack   = imem_req & ~stall;
  assign dmem_rdata = env_mem[dmem_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= '0;
    end else if (dmem_we) begin
      env_mem[dmem_addr] <= dmem_wdata;
    end
  end

  // Reference model: architectural state advanced one instruction phase per clock
  int            m_phase;
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  logic [DW-1:0] m_out;
  logic [3:0]    m_opc;
  logic [DW-1:0] m_op;
  logic          m_c;
  logic          m_z;
  logic          m_err;
  logic [AW-1:0] m_stack [$];
  logic [DW-1:0] m_dmem [16];

  task automatic model_add(input int x);
    int s;
    s     = int'(m_acc) + x;
    m_c   = (s >= 16);
    m_acc = DW'(s);
    m_z   = (m_acc == 0);
  endtask

  task automatic model_exec();
    m_phase = PH_FETCH;
    case (m_opc)
      4'h0: m_acc = m_op;
      4'h1: model_add(int'(m_op));
      4'h2: begin
        m_c   = (m_acc >= m_op);
        m_acc = m_acc - m_op;
        m_z   = (m_acc == 0);
      end
      4'h3: begin
        m_c = (m_acc >= m_op);
        m_z = (m_acc == m_op);
      end
      4'h4: begin
        m_acc = ~(m_acc & m_op);
        m_z   = (m_acc == 0);
      end
      4'h5: m_acc = m_dmem[m_op];
      4'h6: m_dmem[m_op] = m_acc;
      4'h7: m_acc = in_port;
      4'h8: m_out = m_acc;
      4'hD: begin
        if (m_stack.size() == 0) begin
          m_err   = 1'b1;
          m_phase = PH_HALT;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
      4'hE: model_add(int'(m_dmem[m_op]));
      4'hF: m_phase = PH_HALT;
      default: ;
    endcase
  endtask

  task automatic model_branch();
    logic [AW-1:0] tgt;
    logic          tk;
    tgt = {m_op, rom[m_pc]};
    tk  = (m_opc == 4'h9) || (m_opc == 4'hC) || ((m_opc == 4'hA) && m_c) ||
          ((m_opc == 4'hB) && !m_z);
    if ((m_opc == 4'hC) && (m_stack.size() == SD)) begin
      m_err   = 1'b1;
      m_phase = PH_HALT;
    end else begin
      if (m_opc == 4'hC) m_stack.push_back(m_pc + 12'd1);
      m_pc    = tk ? tgt : m_pc + 12'd1;
      m_phase = PH_FETCH;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_FETCH;
      m_pc    = '0;
      m_acc   = '0;
      m_out   = '0;
      m_opc   = '0;
      m_op    = '0;
      m_c     = 1'b0;
      m_z     = 1'b0;
      m_err   = 1'b0;
      m_stack.delete();
      for (int i = 0; i < 16; i++) m_dmem[i] = '0;
    end else begin
      case (m_phase)
        PH_FETCH: begin
          if (!stall) begin
            m_opc   = rom[m_pc][7:4];
            m_op    = rom[m_pc][3:0];
            m_pc    = m_pc + 12'd1;
            m_phase = ((m_opc >= 4'h9) && (m_opc <= 4'hC)) ? PH_ADDR : PH_EXEC;
          end
        end
        PH_EXEC: model_exec();
        PH_ADDR: if (!stall) model_branch();
        default: ;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("imem_req", imem_req, (m_phase == PH_FETCH) || (m_phase == PH_ADDR));
    check_output("imem_addr", imem_addr, m_pc);
    check_output("pc", pc, m_pc);
    check_output("acc", acc, m_acc);
    check_output("carry", carry, m_c);
    check_output("zero", zero, m_z);
    check_output("out_port", out_port, m_out);
    check_output("out_strobe", out_strobe, (m_phase == PH_EXEC) && (m_opc == 4'h8));
    check_output("dmem_we", dmem_we, (m_phase == PH_EXEC) && (m_opc == 4'h6));
    check_output("dmem_wdata", dmem_wdata, m_acc);
    check_output("exec_phase", exec_phase, (m_phase == PH_EXEC) || (m_phase == PH_ADDR));
    check_output("halted", halted, m_phase == PH_HALT);
    check_output("stack_err", stack_err, m_err);
    if (m_phase == PH_EXEC) check_output("dmem_addr", dmem_addr, m_op);
  end

  // Holds reset over two edges, loads a program, then releases just after a falling edge
  task automatic apply_stimulus(input int prog);
    @(negedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    case (prog)
      1: begin rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h80; rom[3] = 8'hF0; end
      2: begin
        rom[0] = 8'h0F; rom[1] = 8'h11; rom[2] = 8'hB0; rom[3] = 8'h55;
        rom[4] = 8'hA1; rom[5] = 8'h23;
      end
      3: begin rom[0] = 8'h07; rom[1] = 8'h12; rom[2] = 8'hF0; end
      4: begin
        rom[0] = 8'hC0; rom[1] = 8'h10; rom[16] = 8'hC0; rom[17] = 8'h20;
        rom[32] = 8'hC0; rom[33] = 8'h30;
      end
      5: begin rom[0] = 8'hC0; rom[1] = 8'h10; rom[16] = 8'h09; rom[17] = 8'hD0; rom[2] = 8'hD0; end
      6: begin
        rom[0] = 8'h0A; rom[1] = 8'h63; rom[2] = 8'h00; rom[3] = 8'h53;
        rom[4] = 8'hE3; rom[5] = 8'h25; rom[6] = 8'h3F; rom[7] = 8'h46;
        rom[8] = 8'h70; rom[9] = 8'hB0; rom[10] = 8'h0C;
        rom[12] = 8'h80; rom[13] = 8'h90; rom[14] = 8'h0F; rom[15] = 8'h65;
      end
      default: ;
    endcase
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    in_port  = 4'hC;

    $display("[TB] program 1: LIT 5, ADDI 3, OUT");
    apply_stimulus(1);
    wait_edges(5);
    check_output("t1_strobe_on", out_strobe, 1);
    wait_edges(1);
    check_output("t1_out_port", out_port, 8);
    check_output("t1_pc_after_3", pc, 3);
    check_output("t1_strobe_off", out_strobe, 0);
    wait_edges(2);
    check_output("t1_halted", halted, 1);

    $display("[TB] program 2: carry/zero and conditional jumps");
    apply_stimulus(2);
    wait_edges(4);
    check_output("t2_acc", acc, 0);
    check_output("t2_carry", carry, 1);
    check_output("t2_zero", zero, 1);
    wait_edges(2);
    check_output("t2_jnz_skipped", pc, 12'h004);
    wait_edges(2);
    check_output("t2_jc_taken", pc, 12'h123);

    $display("[TB] program 3: fetch stall");
    apply_stimulus(3);
    wait_edges(2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_edges(1);
      check_output("t3_pc_held", pc, 1);
      check_output("t3_acc_held", acc, 7);
      check_output("t3_addr_held", imem_addr, 1);
      check_output("t3_req_held", imem_req, 1);
    end
    stall = 1'b0;
    wait_edges(2);
    check_output("t3_acc_after", acc, 9);

    $display("[TB] program 4: call overflow");
    apply_stimulus(4);
    wait_edges(4);
    check_output("t4_second_call", pc, 12'h020);
    wait_edges(2);
    check_output("t4_stack_err", stack_err, 1);
    check_output("t4_halted", halted, 1);
    check_output("t4_pc_held", pc, 12'h021);
    wait_edges(2);
    check_output("t4_pc_still", pc, 12'h021);
    check_output("t4_no_req", imem_req, 0);

    $display("[TB] program 5: return and empty-stack return");
    apply_stimulus(5);
    wait_edges(6);
    check_output("t5_ret_pc", pc, 2);
    check_output("t5_acc", acc, 9);
    wait_edges(2);
    check_output("t5_stack_err", stack_err, 1);
    check_output("t5_halted", halted, 1);
    check_output("t5_pc_held", pc, 3);

    $display("[TB] program 6: memory, ALU mix, reset during exec");
    apply_stimulus(6);
    wait_edges(3);
    check_output("t6_st_we", dmem_we, 1);
    check_output("t6_st_addr", dmem_addr, 3);
    check_output("t6_st_data", dmem_wdata, 4'hA);
    wait_edges(1);
    check_output("t6_we_one_cycle", dmem_we, 0);
    wait_edges(4);
    check_output("t6_ld_acc", acc, 4'hA);
    wait_edges(8);
    check_output("t6_nand_acc", acc, 4'h9);
    check_output("t6_nand_carry", carry, 1);
    check_output("t6_nand_zero", zero, 0);
    wait_edges(6);
    check_output("t6_out_port", out_port, 4'hC);
    wait_edges(3);
    check_output("t6_exec_we", dmem_we, 1);
    #1 reset = 1'b1;
    #1;
    check_output("t6_rst_we", dmem_we, 0);
    check_output("t6_rst_pc", pc, 0);
    check_output("t6_rst_acc", acc, 0);
    check_output("t6_rst_flags", {carry, zero}, 0);
    check_output("t6_rst_out", out_port, 0);
    check_output("t6_rst_exec", exec_phase, 0);
    check_output("t6_rst_halted", halted, 0);

    $display("[TB] program 1 again: reset during stalled fetch");
    apply_stimulus(1);
    wait_edges(2);
    stall = 1'b1;
    wait_edges(1);
    #1 reset = 1'b1;
    #1;
    check_output("t7_rst_pc", pc, 0);
    stall = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("t7_req", imem_req, 1);
    check_output("t7_addr", imem_addr, 0);
    wait_edges(2);
    check_output("t7_acc", acc, 5);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
